fp_vaddsub_seq: RTL and testbench

- Sequences the shared combinational fp_addsub datapath over a whole vector instruction: vd[i] = vs1[i] ± vs2[i] for i = 0..vl-1.
- Accepts one command per instruction via valid/ready, reads element pairs from the vector register file and drives the FP unit.
- Registers each result and writes it back at one element per cycle, then pulses done.
- Sits between the coprocessor decode/issue logic and the VRF/FP add-sub unit.

---
 rtl/fp_vaddsub_seq_if.sv | 50 +++++
 rtl/fp_vaddsub_seq.sv | 188 ++++++++++++++++++
 tb/tb_fp_vaddsub_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_vaddsub_seq_if.sv
// fp_vaddsub_seq_if
//   Bundles the command handshake, VRF read/write ports, FP add/sub unit
//   hookup and status of the vector add/sub sequencer.
//   slave  : the sequencer side (takes commands, drives VRF/FU requests).
//   master : the issuing/environment side (decode, VRF, FP unit).
//   Parameters: IDX_W element index width, VREG_W register specifier width.
interface fp_vaddsub_seq_if #(
  parameter int IDX_W  = 5,
  parameter int VREG_W = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IDX_W:0]    cmd_vl;
  logic              cmd_sub;
  logic [VREG_W-1:0] cmd_vs1;
  logic [VREG_W-1:0] cmd_vs2;
  logic [VREG_W-1:0] cmd_vd;
  logic              rf_rd_en;
  logic [VREG_W-1:0] rf_rd_vs1;
  logic [VREG_W-1:0] rf_rd_vs2;
  logic [IDX_W-1:0]  rf_rd_idx;
  logic [31:0]       rf_rd_data1;
  logic [31:0]       rf_rd_data2;
  logic [31:0]       fu_a;
  logic [31:0]       fu_b;
  logic              fu_sub;
  logic [31:0]       fu_y;
  logic              rf_wr_en;
  logic [VREG_W-1:0] rf_wr_vd;
  logic [IDX_W-1:0]  rf_wr_idx;
  logic [31:0]       rf_wr_data;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_vl, cmd_sub, cmd_vs1, cmd_vs2, cmd_vd,
    input  rf_rd_data1, rf_rd_data2, fu_y,
    output cmd_ready, rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_idx,
    output fu_a, fu_b, fu_sub,
    output rf_wr_en, rf_wr_vd, rf_wr_idx, rf_wr_data, busy, done
  );

  modport master (
    output cmd_valid, cmd_vl, cmd_sub, cmd_vs1, cmd_vs2, cmd_vd,
    output rf_rd_data1, rf_rd_data2, fu_y,
    input  cmd_ready, rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_idx,
    input  fu_a, fu_b, fu_sub,
    input  rf_wr_en, rf_wr_vd, rf_wr_idx, rf_wr_data, busy, done
  );
endinterface

// File: rtl/fp_vaddsub_seq.sv
// fp_vaddsub_seq
//   Runs one vector add/sub instruction vd[i] = vs1[i] +/- vs2[i] over
//   i = 0..vl-1 through the shared combinational FP add/sub unit.
//   Pipeline: read issue (RUN) -> execute (data returns, FU combinational)
//   -> write stage (registered result written back one element per cycle).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   bus (slave modport) command handshake, VRF read/write, FU operands and
//                       result, busy/done status
//   Optional (macro FP_VADDSUB_SEQ_PERF_CNT_EN):
//   perf_clr            synchronous clear of the written-element counter
//   perf_elem_cnt       count of rf_wr_en cycles since reset (wraps)
module fp_vaddsub_seq #(
  parameter int VLMAX  = 32,
  parameter int IDX_W  = 5,
  parameter int VREG_W = 5
) (
  input  logic clk,
  input  logic reset,
`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
  input  logic        perf_clr,
  output logic [31:0] perf_elem_cnt,
`endif
  fp_vaddsub_seq_if.slave bus
);
  localparam logic [IDX_W:0] VLMAX_C = (IDX_W+1)'(VLMAX);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q,   state_d;
  logic [IDX_W:0]    vl_q,      vl_d;
  logic [IDX_W:0]    cnt_q,     cnt_d;
  logic              sub_q,     sub_d;
  logic [VREG_W-1:0] vs1_q,     vs1_d;
  logic [VREG_W-1:0] vs2_q,     vs2_d;
  logic [VREG_W-1:0] vd_q,      vd_d;
  logic              rd_vld_q,  rd_vld_d;
  logic [IDX_W-1:0]  rd_idx_q,  rd_idx_d;
  logic              wr_vld_q,  wr_vld_d;
  logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              accept_s;
  logic [IDX_W:0]    vl_clamp_s;

  // Command acceptance and element-count clamp to VLMAX
  always_comb begin
    accept_s = bus.cmd_valid && ((state_q == S_IDLE) || (state_q == S_DONE));
    if (bus.cmd_vl > VLMAX_C) begin
      vl_clamp_s = VLMAX_C;
    end else begin
      vl_clamp_s = bus.cmd_vl;
    end
  end

  // Next-state, command latch, read issue and pipeline advance
  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vd_d      = vd_q;
    rd_vld_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    // Execute stage always moves into the write stage one cycle later.
    wr_vld_d  = rd_vld_q;
    wr_idx_d  = rd_vld_q ? rd_idx_q : wr_idx_q;
    wr_data_d = rd_vld_q ? bus.fu_y : wr_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          vl_d  = vl_clamp_s;
          sub_d = bus.cmd_sub;
          vs1_d = bus.cmd_vs1;
          vs2_d = bus.cmd_vs2;
          vd_d  = bus.cmd_vd;
          cnt_d = '0;
          // An empty vector skips straight to the completion pulse.
          if (vl_clamp_s == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rd_vld_d = 1'b1;
        rd_idx_d = cnt_q[IDX_W-1:0];
        cnt_d    = cnt_q + ONE_C;
        if (cnt_q == (vl_q - ONE_C)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // No reads are issued here, so once the execute flag is clear both
        // flags are clear at the next edge and the last write is on the bus
        // now; done can follow directly.
        if (!rd_vld_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vl_q      <= '0;
      cnt_q     <= '0;
      sub_q     <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vd_q      <= vd_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      wr_vld_q  <= wr_vld_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.rf_rd_en   = (state_q == S_RUN);
  assign bus.rf_rd_vs1  = vs1_q;
  assign bus.rf_rd_vs2  = vs2_q;
  assign bus.rf_rd_idx  = cnt_q[IDX_W-1:0];
  // Operands are gated so the FP unit sees zeros outside the execute cycle.
  assign bus.fu_a       = rd_vld_q ? bus.rf_rd_data1 : 32'h0000_0000;
  assign bus.fu_b       = rd_vld_q ? bus.rf_rd_data2 : 32'h0000_0000;
  assign bus.fu_sub     = sub_q;
  assign bus.rf_wr_en   = wr_vld_q;
  assign bus.rf_wr_vd   = vd_q;
  assign bus.rf_wr_idx  = wr_idx_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done       = (state_q == S_DONE);

`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Written-element counter; clear wins over a coincident increment
  always_comb begin
    if (perf_clr) begin
      perf_d = 32'h0000_0000;
    end else if (wr_vld_q) begin
      perf_d = perf_q + 32'h0000_0001;
    end else begin
      perf_d = perf_q;
    end
  end

  // Written-element counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 32'h0000_0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_elem_cnt = perf_q;
`endif
endmodule

// File: tb/tb_fp_vaddsub_seq.sv
// tb_fp_vaddsub_seq
//   Self-checking bench for fp_vaddsub_seq. A bench-side VRF and FP add/sub
//   unit stand in for the environment; each accepted command is expanded
//   into a per-cycle schedule of expected reads, FU operands, writes, busy
//   and done, which one compare process checks every cycle.
//   Optional macro FP_VADDSUB_SEQ_PERF_CNT_EN enables perf counter checks.
module tb_fp_vaddsub_seq;
  localparam int VLMAX  = 32;
  localparam int IDX_W  = 5;
  localparam int VREG_W = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  fp_vaddsub_seq_if #(.IDX_W(IDX_W), .VREG_W(VREG_W)) bus ();

`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_elem_cnt;
`endif

  fp_vaddsub_seq #(.VLMAX(VLMAX), .IDX_W(IDX_W), .VREG_W(VREG_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
    .perf_clr      (perf_clr),
    .perf_elem_cnt (perf_elem_cnt),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- float helpers (exact for small integers) -------------
  function automatic logic [63:0] s2d(input logic [31:0] x);
    if (x[30:0] == 31'h0) return {x[31], 63'h0};
    return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int k);
    real r;
    r = k;
    return d2s($realtobits(r));
  endfunction

  function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real ra, rb, ry;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    ry = sub ? (ra - rb) : (ra + rb);
    return d2s($realtobits(ry));
  endfunction

  // ---------------- environment: VRF and FP unit ------------------------
  logic [31:0] vrf [32][32];
  logic [31:0] rd1 = 32'h0;
  logic [31:0] rd2 = 32'h0;
  assign bus.rf_rd_data1 = rd1;
  assign bus.rf_rd_data2 = rd2;
  assign bus.fu_y = fu_model(bus.fu_a, bus.fu_b, bus.fu_sub);

  always @(posedge clk) begin
    if (bus.rf_rd_en) begin
      rd1 <= vrf[bus.rf_rd_vs1][bus.rf_rd_idx];
      rd2 <= vrf[bus.rf_rd_vs2][bus.rf_rd_idx];
    end
    if (!reset && bus.rf_wr_en) vrf[bus.rf_wr_vd][bus.rf_wr_idx] = bus.rf_wr_data;
  end

  // ---------------- expected schedule, keyed by cycle number ------------
  logic [14:0] exp_rd   [int];
  logic [64:0] exp_fu   [int];
  logic [41:0] exp_wr   [int];
  bit          exp_busy [int];
  bit          exp_done [int];
  int ready_from  = 0;
  int last_base   = 0;
  int wr_seen     = 0;
  int rd_seen     = 0;
  int last_wr_idx = -1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_cycle(input int t);
    chk("cmd_ready", 96'(bus.cmd_ready), 96'(t >= ready_from));
    chk("rd_en", 96'(bus.rf_rd_en), 96'(exp_rd.exists(t)));
    if (exp_rd.exists(t)) chk("rd_fields", {bus.rf_rd_vs1, bus.rf_rd_vs2, bus.rf_rd_idx}, 96'(exp_rd[t]));
    chk("wr_en", 96'(bus.rf_wr_en), 96'(exp_wr.exists(t)));
    if (exp_wr.exists(t)) chk("wr_fields", {bus.rf_wr_vd, bus.rf_wr_idx, bus.rf_wr_data}, 96'(exp_wr[t]));
    if (exp_fu.exists(t)) chk("fu_ops", {bus.fu_sub, bus.fu_a, bus.fu_b}, 96'(exp_fu[t]));
    else chk("fu_idle", {bus.fu_a, bus.fu_b}, 96'h0);
    chk("busy", 96'(bus.busy), 96'(exp_busy.exists(t)));
    chk("done", 96'(bus.done), 96'(exp_done.exists(t)));
    if (bus.rf_wr_en) begin
      wr_seen++;
      last_wr_idx = int'(bus.rf_wr_idx);
    end
    if (bus.rf_rd_en) rd_seen++;
  endtask

  // Single compare process, sampling after the active edge settles
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cmp_cycle(cyc);
    end
  end

  // Present a command, wait for acceptance and expand it into the schedule
  task automatic send(input int vl_raw, input bit sub, input int vs1, input int vs2, input int vd, input bit hold);
    int vl, base, guard, done_t;
    bus.cmd_vl    = 6'(vl_raw);
    bus.cmd_sub   = sub;
    bus.cmd_vs1   = 5'(vs1);
    bus.cmd_vs2   = 5'(vs2);
    bus.cmd_vd    = 5'(vd);
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (cyc < ready_from && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: waited %0d cycles, required acceptance", guard);
      bus.cmd_valid = 1'b0;
      return;
    end
    base = cyc;
    vl = (vl_raw > VLMAX) ? VLMAX : vl_raw;
    for (int i = 0; i < vl; i++) begin
      exp_rd[base + 1 + i] = {5'(vs1), 5'(vs2), 5'(i)};
      exp_fu[base + 2 + i] = {sub, vrf[vs1][i], vrf[vs2][i]};
      exp_wr[base + 3 + i] = {5'(vd), 5'(i), fu_model(vrf[vs1][i], vrf[vs2][i], sub)};
    end
    if (vl > 0) for (int t = base + 1; t <= base + vl + 2; t++) exp_busy[t] = 1'b1;
    done_t = (vl == 0) ? base + 1 : base + vl + 3;
    exp_done[done_t] = 1'b1;
    ready_from = done_t;
    last_base = base;
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc <= ready_from && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: waited %0d cycles, required idle", guard);
    end
  endtask

  initial begin
    int b1, b2, w0, r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_vl    = 6'd0;
    bus.cmd_sub   = 1'b0;
    bus.cmd_vs1   = 5'd0;
    bus.cmd_vs2   = 5'd0;
    bus.cmd_vd    = 5'd0;
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < 32; i++)
        vrf[r][i] = i2f(int'($urandom_range(0, 2000)) - 1000);

    // Pin the FU stand-in to hand-computed IEEE-754 results.
    chk("model_add", 96'(fu_model(32'h3F80_0000, 32'h4000_0000, 1'b0)), 96'h4040_0000);
    chk("model_sub", 96'(fu_model(32'h4040_0000, 32'h3F80_0000, 1'b1)), 96'h4000_0000);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Add vl=4: 1.0 + 2.0 = 3.0, done in cycle 7
    for (int i = 0; i < 32; i++) begin
      vrf[1][i] = 32'h3F80_0000;
      vrf[2][i] = 32'h4000_0000;
      vrf[4][i] = 32'h4040_0000;
    end
    send(4, 1'b0, 1, 2, 3, 1'b0);
    b1 = last_base;
    chk("t1_done_cycle", 96'(exp_done.exists(b1 + 7)), 96'h1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("t1_vd_data", 96'(vrf[3][i]), 96'h4040_0000);

    // Subtract vl=2: 3.0 - 1.0 = 2.0, done in cycle 5
    send(2, 1'b1, 4, 1, 5, 1'b0);
    b1 = last_base;
    chk("t2_done_cycle", 96'(exp_done.exists(b1 + 5)), 96'h1);
    wait_idle();
    chk("t2_vd0", 96'(vrf[5][0]), 96'h4000_0000);
    chk("t2_vd1", 96'(vrf[5][1]), 96'h4000_0000);

    // vl=0: no traffic, done in cycle 1
    w0 = wr_seen;
    r0 = rd_seen;
    send(0, 1'b0, 1, 2, 6, 1'b0);
    chk("t3_done_cycle", 96'(exp_done.exists(last_base + 1)), 96'h1);
    wait_idle();
    chk("t3_no_reads", 96'(rd_seen - r0), 96'h0);
    chk("t3_no_writes", 96'(wr_seen - w0), 96'h0);

    // cmd_vl=40 clamps to 32
    w0 = wr_seen;
    r0 = rd_seen;
    send(40, 1'b0, 6, 7, 8, 1'b0);
    wait_idle();
    chk("t4_reads", 96'(rd_seen - r0), 96'd32);
    chk("t4_writes", 96'(wr_seen - w0), 96'd32);
    chk("t4_last_idx", 96'(last_wr_idx), 96'd31);

    // Back-to-back vl=3 then vl=1 with valid held; second has vd == vs1
    send(3, 1'b0, 9, 10, 11, 1'b1);
    b1 = last_base;
    send(1, 1'b1, 12, 13, 12, 1'b0);
    b2 = last_base;
    chk("t5_b2b_accept", 96'(b2 - b1), 96'd6);
    wait_idle();

    // Reset in cycle 3 of a vl=8 command
    send(8, 1'b1, 14, 15, 16, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_rd.delete();
    exp_fu.delete();
    exp_wr.delete();
    exp_busy.delete();
    exp_done.delete();
    ready_from = 0;
    #1;
    chk("rst_outs0", {bus.rf_rd_en, bus.rf_wr_en, bus.busy, bus.done, bus.fu_sub,
                      bus.rf_rd_idx, bus.rf_wr_idx, bus.rf_rd_vs1, bus.rf_rd_vs2, bus.rf_wr_vd}, 96'h0);
    chk("rst_data0", {bus.fu_a, bus.fu_b, bus.rf_wr_data}, 96'h0);
    chk("rst_ready", 96'(bus.cmd_ready), 96'h1);
    w0 = wr_seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_writes", 96'(wr_seen - w0), 96'h0);
`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
    chk("perf_after_rst", 96'(perf_elem_cnt), 96'h0);
`endif
    send(5, 1'b0, 17, 18, 19, 1'b0);
    wait_idle();
`ifdef FP_VADDSUB_SEQ_PERF_CNT_EN
    chk("perf_after_vl5", 96'(perf_elem_cnt), 96'd5);
`endif

    // Randomized commands, some with valid held into the next command
    for (int n = 0; n < 14; n++) begin
      send(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), (n == 13) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
